// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median line-buffer front end.
package median_pkg;

    localparam int NUM_BANKS  = 3;
    localparam int DEF_ADDR_W = 11;

    typedef logic [1:0] bank_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic bank_idx_t next_bank(input bank_idx_t idx);
        return (idx == bank_idx_t'(NUM_BANKS - 1)) ? bank_idx_t'(0) : idx + bank_idx_t'(1);
    endfunction

endpackage

// File: rtl/bank_rotator.sv
// Mod-3 bank index counter with clear-over-advance priority and one-hot decode.
import median_pkg::*;

module bank_rotator (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv,
    input  logic            clr,
    output logic [1:0]      idx,
    output logic [2:0]      onehot
);

    bank_idx_t idx_q;
    bank_idx_t idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = bank_idx_t'(0);
        end else if (adv) begin
            idx_d = next_bank(idx_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= bank_idx_t'(0);
        end else begin
            idx_q <= idx_d;
        end
    end

    always_comb begin
        onehot = 3'b000;
        case (idx_q)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    end

    assign idx = idx_q;

endmodule

// File: rtl/line_buf_ctrl.sv
// Sequences three BRAM line buffers: writes the newest row, shares the column
// address for reading the two older rows, and flags valid window columns.
import median_pkg::*;

module line_buf_ctrl #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              hsync,
    input  logic              pix_valid,
    output logic [2:0]        wr_en,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        wr_bank,
    output logic              win_valid,
    output logic [ADDR_W:0]   width,
    output logic [LINE_W-1:0] line_cnt,
    output logic              ovf
);

    localparam logic [ADDR_W:0] LINE_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     width_q, width_d;
    logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
    logic                ovf_q, ovf_d;
    logic                line_ovf_q, line_ovf_d;
    logic [RD_LAT-1:0]   wv_pipe_q;

    logic                wr_cond;
    logic                run_pix;
    logic                addr_at_max;
    logic                rot_adv;
    logic                rot_clr;
    logic [2:0]          bank_onehot;
    logic [ADDR_W:0]     line_count;

    assign wr_cond     = pix_valid && (state_q != IDLE) && !vsync;
    assign run_pix     = pix_valid && (state_q == RUN) && !vsync;
    assign addr_at_max = (addr_q == {ADDR_W{1'b1}});
    assign line_count  = {1'b0, addr_q} + {{ADDR_W{1'b0}}, wr_cond};

    bank_rotator u_rot (
        .clk    (clk),
        .rst    (rst),
        .adv    (rot_adv),
        .clr    (rot_clr),
        .idx    (wr_bank),
        .onehot (bank_onehot)
    );

    assign wr_en = bank_onehot & {3{wr_cond}};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        width_d    = width_q;
        line_cnt_d = line_cnt_q;
        ovf_d      = ovf_q;
        line_ovf_d = line_ovf_q;
        rot_adv    = 1'b0;
        rot_clr    = 1'b0;

        if (vsync) begin
            // Frame restart wins over hsync and any pixel in the same cycle.
            state_d    = FILL;
            addr_d     = '0;
            line_cnt_d = '0;
            ovf_d      = 1'b0;
            line_ovf_d = 1'b0;
            rot_clr    = 1'b1;
        end else if (state_q != IDLE) begin
            if (wr_cond) begin
                if (addr_at_max) begin
                    ovf_d      = 1'b1;
                    line_ovf_d = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            if (hsync) begin
                // An overflowed line reports the full buffer length, not the held address.
                width_d    = (line_ovf_q || (wr_cond && addr_at_max)) ? LINE_MAX : line_count;
                addr_d     = '0;
                line_ovf_d = 1'b0;
                rot_adv    = 1'b1;
                if (line_cnt_q != {LINE_W{1'b1}}) begin
                    line_cnt_d = line_cnt_q + 1'b1;
                end
                if ((state_q == FILL) && (line_cnt_q == LINE_W'(1))) begin
                    state_d = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            width_q    <= '0;
            line_cnt_q <= '0;
            ovf_q      <= 1'b0;
            line_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            width_q    <= width_d;
            line_cnt_q <= line_cnt_d;
            ovf_q      <= ovf_d;
            line_ovf_q <= line_ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wv_pipe_q <= '0;
        end else if (vsync) begin
            wv_pipe_q <= '0;
        end else begin
            wv_pipe_q[0] <= run_pix;
            for (int i = 1; i < RD_LAT; i++) begin
                wv_pipe_q[i] <= wv_pipe_q[i-1];
            end
        end
    end

    assign addr      = addr_q;
    assign width     = width_q;
    assign line_cnt  = line_cnt_q;
    assign ovf       = ovf_q;
    assign win_valid = wv_pipe_q[RD_LAT-1];

endmodule
